// File: rtl/uart_transmitter.sv
// 8-bit UART transmitter with a one-entry holding register, optional parity and 1/2 stop bits.
// Every state change is gated by clock_enable, so one bit time is TICKS_PER_BIT enabled edges.
module uart_transmitter #(
  parameter int TICKS_PER_BIT = 16,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic       CLKIN,
  input  logic       RESETN,
  input  logic       clock_enable,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);
  localparam int              CW        = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   TICK_LAST = CW'(TICKS_PER_BIT - 1);
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic          stop_cnt, stop_n;
  logic [7:0]    shifter, hold;
  logic          hold_full;
  logic          tx_r, tx_n;
  logic          load, bit_end, par_bit;

  assign bit_end = (cnt == TICK_LAST);
  assign par_bit = (PARITY == 2) ? ~(^shifter) : ^shifter;

  // tx_n is the line level for the state being entered, so tx stays a plain flop.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    stop_n  = stop_cnt;
    tx_n    = tx_r;
    load    = 1'b0;
    case (state)
      S_IDLE:  if (hold_full) load = 1'b1;
      S_START: if (bit_end) begin
        state_n = S_DATA;
        idx_n   = 3'd0;
        tx_n    = shifter[0];
      end
      S_DATA: if (bit_end) begin
        if (idx == 3'd7) begin
          if (PARITY != 0) begin
            state_n = S_PARITY;
            tx_n    = par_bit;
          end else begin
            state_n = S_STOP;
            stop_n  = 1'b0;
            tx_n    = 1'b1;
          end
        end else begin
          idx_n = idx + 3'd1;
          tx_n  = shifter[idx_n];
        end
      end
      S_PARITY: if (bit_end) begin
        state_n = S_STOP;
        stop_n  = 1'b0;
        tx_n    = 1'b1;
      end
      S_STOP: if (bit_end) begin
        if (stop_cnt == STOP_LAST) begin
          if (hold_full) load = 1'b1;
          else begin
            state_n = S_IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          stop_n = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (state != S_IDLE) cnt_n = bit_end ? '0 : cnt + CW'(1);
    // Loading from IDLE or from the last stop edge both start a fresh start bit.
    if (load) begin
      state_n = S_START;
      cnt_n   = '0;
      tx_n    = 1'b0;
    end
  end

  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= 3'd0;
      stop_cnt  <= 1'b0;
      shifter   <= 8'h00;
      hold      <= 8'h00;
      hold_full <= 1'b0;
      tx_r      <= 1'b1;
    end else if (clock_enable) begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      stop_cnt <= stop_n;
      tx_r     <= tx_n;
      if (load) begin
        shifter   <= hold;
        hold_full <= 1'b0;
      end else if (valid && !hold_full) begin
        hold      <= data;
        hold_full <= 1'b1;
      end
    end
  end

  assign ready = ~hold_full;
  assign busy  = (state != S_IDLE);
  assign tx    = tx_r;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: expected frames are queued at acceptance and
// checked tick-by-tick by a line monitor; two extra instances cover even/odd parity.
module tb_uart_transmitter;
  logic       CLKIN = 1'b0, RESETN = 1'b0, clock_enable = 1'b0;
  logic       valid = 1'b0, valid_p = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, tx, busy;
  logic       ready_p1, tx_p1, busy_p1, ready_p2, tx_p2, busy_p2;

  int errs = 0, checks = 0;

  always #5 CLKIN = ~CLKIN;

  uart_transmitter dut (
    .CLKIN(CLKIN), .RESETN(RESETN), .clock_enable(clock_enable), .data(data),
    .valid(valid), .ready(ready), .tx(tx), .busy(busy));

  uart_transmitter #(.PARITY(1)) dut_p1 (
    .CLKIN(CLKIN), .RESETN(RESETN), .clock_enable(clock_enable), .data(data),
    .valid(valid_p), .ready(ready_p1), .tx(tx_p1), .busy(busy_p1));

  uart_transmitter #(.PARITY(2)) dut_p2 (
    .CLKIN(CLKIN), .RESETN(RESETN), .clock_enable(clock_enable), .data(data),
    .valid(valid_p), .ready(ready_p2), .tx(tx_p2), .busy(busy_p2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // clock_enable: always 1, or 1-of-3 cycles when ce_mode is set
  bit ce_mode = 1'b0;
  int cyc = 0;
  initial forever begin
    @(posedge CLKIN);
    cyc++;
    #2;
    clock_enable = ce_mode ? (cyc % 3 == 0) : 1'b1;
  end

  // scoreboard: frame levels LSB first (start, d0..d7, stop)
  logic [9:0] sb_q[$];
  int         starts[$];
  int         en_ticks = 0;
  bit         in_frame = 1'b0, chk_end = 1'b0;
  logic [9:0] cur;
  int         pos = 0, bit_ok = 0;
  logic       tx_prev = 1'b1, busy_prev = 1'b0, ce_s;

  initial forever begin
    @(posedge CLKIN);
    ce_s = clock_enable;
    #1;
    if (!RESETN) begin
      in_frame = 1'b0;
      chk_end  = 1'b0;
    end else if (!ce_s) begin
      chk("freeze", {tx, busy}, {tx_prev, busy_prev});
    end else begin
      en_ticks++;
      if (chk_end) begin
        chk_end = 1'b0;
        if (tx !== 1'b0) chk("idle_after", {tx, busy}, 2'b10);
      end
      if (!in_frame && tx === 1'b0) begin
        if (sb_q.size() == 0) begin
          chk("unexp_frame", 0, 1);
          cur = '1;
        end else begin
          cur = sb_q.pop_front();
        end
        in_frame = 1'b1;
        pos      = 0;
        bit_ok   = 0;
        starts.push_back(en_ticks);
      end
      if (in_frame) begin
        if (tx === cur[pos/16]) bit_ok++;
        if (pos % 16 == 15) begin
          chk($sformatf("bit%0d", pos/16), bit_ok, 16);
          chk("busy_in_frame", busy, 1);
          bit_ok = 0;
        end
        pos++;
        if (pos == 160) begin
          in_frame = 1'b0;
          chk_end  = 1'b1;
        end
      end
    end
    tx_prev   = tx;
    busy_prev = busy;
  end

  task automatic send(input logic [7:0] b);
    int   n = 0;
    logic r;
    bit   acc = 1'b0;
    @(negedge CLKIN);
    data  = b;
    valid = 1'b1;
    while (!acc && n < 5000) begin
      r = ready;
      @(posedge CLKIN);
      acc = r && clock_enable;
      if (!acc) begin
        @(negedge CLKIN);
        n++;
      end
    end
    if (acc) sb_q.push_back({1'b1, b, 1'b0});
    else chk("send_timeout", 0, 1);
    @(negedge CLKIN);
    valid = 1'b0;
    if (acc) chk("rdy_after_acc", ready, 0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge CLKIN);
      n++;
    end while ((in_frame || sb_q.size() != 0 || busy) && n < budget);
    chk("idle_timeout", n < budget, 1);
  endtask

  logic [10:0] exp1, exp2;
  int          n0, s0, k;

  initial begin
    repeat (3) @(negedge CLKIN);
    chk("rst_tx", tx, 1);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    RESETN = 1'b1;

    for (int i = 0; i < 500; i++) begin
      @(negedge CLKIN);
      chk("idle", {tx, ready, busy}, 3'b110);
    end

    send(8'hA5);
    wait_idle(400);

    // back-to-back: second byte held, start bit on the last stop edge
    n0 = starts.size();
    send(8'h55);
    repeat (40) @(negedge CLKIN);
    send(8'hAA);
    repeat (60) @(negedge CLKIN);
    chk("held_ready", ready, 0);
    k = 0;
    while (starts.size() < n0 + 2 && k < 400) begin
      @(negedge CLKIN);
      k++;
    end
    chk("ready_after_load", ready, 1);
    wait_idle(400);
    if (starts.size() >= n0 + 2) chk("b2b_gap", starts[n0+1] - starts[n0], 160);
    else chk("b2b_frames", starts.size(), n0 + 2);

    // sparse clock_enable mid-frame
    send(8'h96);
    repeat (20) @(negedge CLKIN);
    ce_mode = 1'b1;
    wait_idle(3000);
    ce_mode = 1'b0;
    repeat (4) @(negedge CLKIN);

    // parity instances, 0x07 has three ones
    exp1 = {1'b1, 1'b1, 8'h07, 1'b0};
    exp2 = {1'b1, 1'b0, 8'h07, 1'b0};
    chk("p_ready", {ready_p1, ready_p2}, 2'b11);
    data    = 8'h07;
    valid_p = 1'b1;
    @(negedge CLKIN);
    valid_p = 1'b0;
    for (int j = 1; j <= 177; j++) begin
      @(negedge CLKIN);
      if ((j - 1) % 16 == 8 && (j - 1) / 16 < 11) begin
        chk($sformatf("p1_bit%0d", (j-1)/16), tx_p1, exp1[(j-1)/16]);
        chk($sformatf("p2_bit%0d", (j-1)/16), tx_p2, exp2[(j-1)/16]);
      end
      if (j == 176) chk("p_busy_last", {busy_p1, busy_p2}, 2'b11);
      if (j == 177) chk("p_done", {tx_p1, busy_p1, tx_p2, busy_p2}, 4'b1010);
    end

    // reset during data bit 4 with a byte held
    n0 = starts.size();
    send(8'h2C);
    k = 0;
    while (starts.size() <= n0 && k < 100) begin
      @(negedge CLKIN);
      k++;
    end
    s0 = (starts.size() > n0) ? starts[n0] : en_ticks;
    send(8'hD3);
    k = 0;
    while (en_ticks < s0 + 85 && k < 400) begin
      @(negedge CLKIN);
      k++;
    end
    chk("pre_rst_bit4", {tx, busy, ready}, 3'b010);
    RESETN = 1'b0;
    #1;
    chk("rst_mid", {tx, ready, busy}, 3'b110);
    sb_q.delete();
    repeat (3) @(negedge CLKIN);
    RESETN = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLKIN);
      chk("post_rst", {tx, busy, ready}, 3'b101);
    end
    chk("no_frame", starts.size(), n0 + 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
